mssb_rr_arbiter: RTL
====================

// Module: mssb_rr_arbiter
// PURPOSE
//  Round-robin, lock-holding arbiter sharing one resource among N_REQ requesters.
//  Each arbitration picks one requester with an mssbIdx instance (highest set bit wins).
//  That mssbIdx instance sees the masked request vector first, then the full vector.
//  A grant is held while its request stays high, with optional preemption after MAXHOLD cycles.
//  It sits in front of shared datapaths such as bus masters and memory ports.
// PARAMETERS
//  N_REQ    8   number of requesters, 2..16
//  MAXHOLD  4   max consecutive grant cycles before preemption; 0 = unlimited
// PORTS
//  i_clk       in   1                   clock; all flops rise-edge
//  i_arst_n    in   1                   asynchronous active-low reset
//  i_req       in   N_REQ               request vector, level-sensitive
//  o_gnt       out  N_REQ               registered one-hot grant, or zero
//  o_gntIdx    out  $clog2(N_REQ)       binary index of o_gnt; 0 when no grant
//  o_gntValid  out  1                   equals |o_gnt
//  o_preempt   out  1                   1-cycle pulse on the cycle a grant changes due to MAXHOLD
// BEHAVIOUR
//  Reset (async assert, sync deassert by integrator):
//    o_gnt=0, o_gntIdx=0, o_gntValid=0, o_preempt=0; state=IDLE; holdCnt=0; mask=all-ones.
//  Selection function sel(v):
//    m = v & mask; if |m then mssb(m) elif |v then mssb(v) else none.
//  On each new grant to idx k: mask <= (1<<k)-1 (k=0 gives mask 0, so fallback to full vector).
//  IDLE:
//    - if |i_req: o_gnt <= onehot(sel(i_req)) at next edge; state <= BUSY; holdCnt <= 0.
//    - Latency: req high at cycle t gives gnt at t+1.
//  BUSY, holder h:
//    - Release: i_req[h]==0 and other reqs present -> o_gnt <= onehot(sel(i_req)) at the same edge.
//      No idle gap between holders; holdCnt <= 0.
//    - Release with no other reqs: o_gnt <= 0; state <= IDLE; mask unchanged.
//    - Preempt: MAXHOLD!=0, holdCnt==MAXHOLD-1, i_req[h]==1 and |(i_req & ~onehot(h)):
//      o_gnt <= onehot(sel(i_req & ~onehot(h))); o_preempt <= 1; holdCnt <= 0.
//    - Sole holder at limit: i_req[h]==1, no other req, holdCnt==MAXHOLD-1:
//      keep h, holdCnt <= 0, no pulse, mask unchanged.
//    - Otherwise hold: holdCnt <= holdCnt+1 (saturates at MAXHOLD-1; unused when MAXHOLD=0).
//  o_gntIdx and o_gntValid are registered alongside o_gnt and are always consistent with it.
//  o_gnt is never multi-hot. o_gnt is never set for a bit whose i_req was 0 at the deciding edge.
//  o_gnt may lag a dropped request by exactly one cycle; consumers qualify with i_req.
//  holdCnt width is $clog2(MAXHOLD+1), min 1. Unknown/X on i_req is not tolerated (no filtering).
//  Reset asserted mid-grant: outputs clear immediately (async); the next grant after release is a fresh IDLE arbitration from mask=all-ones.
// TESTING (N_REQ=8, MAXHOLD=4 unless stated)
//  1. Reset priority: i_req=8'hFF held through reset -> o_gnt=0 in reset; first edge after release o_gnt=8'h80, o_gntIdx=7.
//  2. Rotation: i_req=8'hA5 constant -> grant idx 7,5,2,0,7 for 4 cycles each; o_preempt pulses at every change.
//  3. Handover: holder idx 7; at cycle t drop req[7] with req=8'h08 -> t+1 o_gnt=8'h08, no o_gntValid=0 cycle.
//  4. Sole requester: i_req=8'h10 for 12 cycles -> o_gnt=8'h10 throughout, o_preempt never asserts.
//  5. Mid-grant reset: assert i_arst_n=0 while o_gnt=8'h04 -> outputs 0 without clock edge.
//     Release with i_req=8'h05 -> o_gnt=8'h04 (mask all-ones).
//  6. Drain and idle: holder idx 3 drops with i_req=0 -> o_gnt=0 next edge.
//     Later i_req=8'h0C -> o_gnt=8'h04 (mask from last grant idx 3 = 8'h07).
//  Checker runs every cycle: one-hot/zero o_gnt, o_gntIdx==index(o_gnt), o_gntValid==|o_gnt, no grant run >MAXHOLD cycles while others request.

Source files
------------

// File: rtl/mssb_rr_arbiter.sv
// Round-robin, lock-holding arbiter: one registered one-hot grant, picked by a
// most-significant-set-bit finder over the rotation-masked (then full) request vector.

module mssb_idx #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Later iterations override earlier ones, so the highest set bit wins.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = IW'(i);
      end
   end

   assign valid = |vec;

endmodule

module mssb_rr_arbiter #(
   parameter int N_REQ   = 8,
   parameter int MAXHOLD = 4
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic [N_REQ-1:0]         i_req,
   output logic [N_REQ-1:0]         o_gnt,
   output logic [$clog2(N_REQ)-1:0] o_gntIdx,
   output logic                     o_gntValid,
   output logic                     o_preempt
);

   localparam int IW = $clog2(N_REQ);
   localparam int HW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'((MAXHOLD > 0) ? MAXHOLD - 1 : 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_reg, state_next;
   logic [N_REQ-1:0] gnt_reg, gnt_next;
   logic [IW-1:0]    idx_reg, idx_next;
   logic             valid_reg, valid_next;
   logic             preempt_reg, preempt_next;
   logic [HW-1:0]    hold_reg, hold_next;
   logic [N_REQ-1:0] mask_reg, mask_next;

   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] masked;
   logic [N_REQ-1:0] pick_vec;
   logic [N_REQ-1:0] pick_onehot;
   logic [IW-1:0]    pick_idx;
   logic             pick_valid;
   logic             holder_req;
   logic             take;

   // The current holder is never a candidate: on release its request is already
   // low, on preemption it must be excluded, and in IDLE gnt_reg is zero.
   assign cand        = i_req & ~gnt_reg;
   assign masked      = cand & mask_reg;
   assign pick_vec    = (|masked) ? masked : cand;
   assign pick_onehot = N_REQ'(1) << pick_idx;
   assign holder_req  = |(i_req & gnt_reg);

   mssb_idx #(.N(N_REQ), .IW(IW)) u_mssb (
      .vec   (pick_vec),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      idx_next     = idx_reg;
      valid_next   = valid_reg;
      preempt_next = 1'b0;
      hold_next    = hold_reg;
      mask_next    = mask_reg;
      take         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               take       = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (!holder_req) begin
               if (pick_valid) begin
                  take = 1'b1;
               end else begin
                  gnt_next   = '0;
                  idx_next   = '0;
                  valid_next = 1'b0;
                  hold_next  = '0;
                  state_next = IDLE;
               end
            end else if ((MAXHOLD != 0) && (hold_reg == HOLD_LAST)) begin
               // A sole holder at the limit simply restarts its count.
               hold_next = '0;
               if (pick_valid) begin
                  take         = 1'b1;
                  preempt_next = 1'b1;
               end
            end else if (MAXHOLD != 0) begin
               hold_next = hold_reg + HW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      if (take) begin
         gnt_next   = pick_onehot;
         idx_next   = pick_idx;
         valid_next = 1'b1;
         hold_next  = '0;
         mask_next  = pick_onehot - N_REQ'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_reg   <= IDLE;
         gnt_reg     <= '0;
         idx_reg     <= '0;
         valid_reg   <= 1'b0;
         preempt_reg <= 1'b0;
         hold_reg    <= '0;
         mask_reg    <= '1;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         idx_reg     <= idx_next;
         valid_reg   <= valid_next;
         preempt_reg <= preempt_next;
         hold_reg    <= hold_next;
         mask_reg    <= mask_next;
      end
   end

   assign o_gnt      = gnt_reg;
   assign o_gntIdx   = idx_reg;
   assign o_gntValid = valid_reg;
   assign o_preempt  = preempt_reg;

endmodule
